floo_axi_rw_initiator: RTL

- Synthesizable AXI4 initiator that writes a deterministic data pattern to a memory region and reads it back to check it.
- It is the requesting end of the narrow/wide HBM AXI ports. It drives a memory model, or a chimney subordinate port, as a self-checking traffic source for the compute-tile array benches and bring-up.
- Only one transaction is outstanding at a time. Each transaction is one INCR write burst, then its B response, then one INCR read burst of the same address, then its R beats.

---
 rtl/floo_axi_rw_initiator.sv | 281 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/floo_axi_rw_initiator.sv
`default_nettype none
// ============================================================================
// Module   : floo_axi_rw_initiator
// Brief    : Self-checking AXI4 traffic initiator. Each transaction writes one
//            INCR burst of a seeded pattern, waits for B, reads the same burst
//            back and checks every R beat. One transaction in flight at a time.
// Revision : 1.0 - initial release
// ============================================================================

package floo_axi_rw_pkg;
    typedef struct packed {
        logic [2:0]  id;
        logic [47:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic        lock;
        logic [3:0]  cache;
        logic [2:0]  prot;
        logic [3:0]  qos;
        logic [3:0]  region;
        logic [5:0]  atop;
        logic [0:0]  user;
    } axi_aw_chan_t;

    typedef struct packed {
        logic [511:0] data;
        logic [63:0]  strb;
        logic         last;
        logic [0:0]   user;
    } axi_w_chan_t;

    typedef struct packed {
        logic [2:0] id;
        logic [1:0] resp;
        logic [0:0] user;
    } axi_b_chan_t;

    typedef struct packed {
        logic [2:0]  id;
        logic [47:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic        lock;
        logic [3:0]  cache;
        logic [2:0]  prot;
        logic [3:0]  qos;
        logic [3:0]  region;
        logic [0:0]  user;
    } axi_ar_chan_t;

    typedef struct packed {
        logic [2:0]   id;
        logic [511:0] data;
        logic [1:0]   resp;
        logic         last;
        logic [0:0]   user;
    } axi_r_chan_t;

    typedef struct packed {
        axi_aw_chan_t aw;
        logic         aw_valid;
        axi_w_chan_t  w;
        logic         w_valid;
        logic         b_ready;
        axi_ar_chan_t ar;
        logic         ar_valid;
        logic         r_ready;
    } axi_req_t;

    typedef struct packed {
        logic        aw_ready;
        logic        ar_ready;
        logic        w_ready;
        logic        b_valid;
        axi_b_chan_t b;
        logic        r_valid;
        axi_r_chan_t r;
    } axi_rsp_t;
endpackage

module floo_axi_rw_initiator #(
    parameter int unsigned         AddrWidth = 48,
    parameter int unsigned         DataWidth = 512,
    parameter int unsigned         IdWidth   = 3,
    parameter int unsigned         UserWidth = 1,
    parameter int unsigned         BurstLen  = 4,
    parameter logic [IdWidth-1:0]  TxnId     = '0,
    parameter logic [31:0]         Seed      = 32'hCAFE_0000,
    parameter type                 axi_req_t = floo_axi_rw_pkg::axi_req_t,
    parameter type                 axi_rsp_t = floo_axi_rw_pkg::axi_rsp_t
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 start_i,
    input  logic [AddrWidth-1:0] base_addr_i,
    input  logic [15:0]          num_txns_i,
    output axi_req_t             axi_req_o,
    input  axi_rsp_t             axi_rsp_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [15:0]          err_cnt_o,
    output logic [AddrWidth-1:0] first_err_addr_o
);

    localparam int unsigned         StrbWidth = DataWidth / 8;
    localparam int unsigned         SizeLog   = $clog2(StrbWidth);
    localparam int unsigned         Lanes     = DataWidth / 32;
    localparam logic [AddrWidth-1:0] TxnStride = AddrWidth'(BurstLen * StrbWidth);
    localparam logic [7:0]          LastBeat  = 8'(BurstLen - 1);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        AW   = 3'd1,
        W    = 3'd2,
        B    = 3'd3,
        AR   = 3'd4,
        R    = 3'd5,
        DONE = 3'd6
    } state_e;

    state_e               state_q, state_d;
    logic [AddrWidth-1:0] addr_q, addr_d;          // A(k) of the current transaction
    logic [15:0]          k_q, k_d;
    logic [15:0]          num_q, num_d;
    logic [7:0]           beat_q, beat_d;
    logic [31:0]          txn_pat_q, txn_pat_d;    // k*BurstLen, pattern index of beat 0
    logic [15:0]          err_cnt_q, err_cnt_d;
    logic [AddrWidth-1:0] first_err_q, first_err_d;

    logic [31:0]          w_pattern;
    logic [DataWidth-1:0] w_data;
    logic                 w_is_last;
    logic                 w_err;
    logic [AddrWidth-1:0] w_err_addr;
    logic [2*UserWidth-1:0] w_unused_rsp;

    assign w_pattern    = Seed ^ (txn_pat_q + 32'(beat_q));
    assign w_data       = {Lanes{w_pattern}};
    assign w_is_last    = (beat_q == LastBeat);
    assign w_unused_rsp = {axi_rsp_i.b.user, axi_rsp_i.r.user};

    // State and datapath registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            k_q         <= '0;
            num_q       <= '0;
            beat_q      <= '0;
            txn_pat_q   <= '0;
            err_cnt_q   <= '0;
            first_err_q <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            k_q         <= k_d;
            num_q       <= num_d;
            beat_q      <= beat_d;
            txn_pat_q   <= txn_pat_d;
            err_cnt_q   <= err_cnt_d;
            first_err_q <= first_err_d;
        end
    end

    // Next-state, beat sequencing, response checking and error logging
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        k_d         = k_q;
        num_d       = num_q;
        beat_d      = beat_q;
        txn_pat_d   = txn_pat_q;
        err_cnt_d   = err_cnt_q;
        first_err_d = first_err_q;
        w_err       = 1'b0;
        w_err_addr  = '0;

        case (state_q)
            IDLE, DONE: begin
                if (start_i) begin
                    addr_d      = base_addr_i;
                    num_d       = num_txns_i;
                    k_d         = '0;
                    beat_d      = '0;
                    txn_pat_d   = '0;
                    err_cnt_d   = '0;
                    first_err_d = '0;
                    state_d     = (num_txns_i == 16'd0) ? DONE : AW;
                end
            end
            AW: if (axi_rsp_i.aw_ready) begin
                beat_d  = '0;
                state_d = W;
            end
            W: if (axi_rsp_i.w_ready) begin
                if (w_is_last) begin
                    beat_d  = '0;
                    state_d = B;
                end else begin
                    beat_d = beat_q + 8'd1;
                end
            end
            B: if (axi_rsp_i.b_valid) begin
                if ((axi_rsp_i.b.resp != 2'b00) || (axi_rsp_i.b.id != TxnId)) begin
                    w_err      = 1'b1;
                    w_err_addr = addr_q;
                end
                state_d = AR;
            end
            AR: if (axi_rsp_i.ar_ready) begin
                beat_d  = '0;
                state_d = R;
            end
            R: if (axi_rsp_i.r_valid) begin
                if ((axi_rsp_i.r.data != w_data) || (axi_rsp_i.r.resp != 2'b00) ||
                    (axi_rsp_i.r.id != TxnId) || (axi_rsp_i.r.last != w_is_last)) begin
                    w_err      = 1'b1;
                    w_err_addr = addr_q + (AddrWidth'(beat_q) << SizeLog);
                end
                if (w_is_last) begin
                    beat_d    = '0;
                    k_d       = k_q + 16'd1;
                    addr_d    = addr_q + TxnStride;
                    txn_pat_d = txn_pat_q + 32'(BurstLen);
                    state_d   = ((k_q + 16'd1) == num_q) ? DONE : AW;
                end else begin
                    beat_d = beat_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Only the first error since start records its address; count saturates
        if (w_err) begin
            if (err_cnt_q == 16'd0) first_err_d = w_err_addr;
            if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
        end
    end

    // AXI request channels, payload only driven while the channel is active
    always_comb begin
        axi_req_o = '0;
        case (state_q)
            AW: begin
                axi_req_o.aw_valid   = 1'b1;
                axi_req_o.aw.id      = TxnId;
                axi_req_o.aw.addr    = addr_q;
                axi_req_o.aw.len     = LastBeat;
                axi_req_o.aw.size    = 3'(SizeLog);
                axi_req_o.aw.burst   = 2'b01;
                axi_req_o.aw.user    = {UserWidth{1'b0}};
            end
            W: begin
                axi_req_o.w_valid    = 1'b1;
                axi_req_o.w.data     = w_data;
                axi_req_o.w.strb     = {StrbWidth{1'b1}};
                axi_req_o.w.last     = w_is_last;
            end
            B:  axi_req_o.b_ready    = 1'b1;
            AR: begin
                axi_req_o.ar_valid   = 1'b1;
                axi_req_o.ar.id      = TxnId;
                axi_req_o.ar.addr    = addr_q;
                axi_req_o.ar.len     = LastBeat;
                axi_req_o.ar.size    = 3'(SizeLog);
                axi_req_o.ar.burst   = 2'b01;
            end
            R:  axi_req_o.r_ready    = 1'b1;
            default: ;
        endcase
    end

    assign busy_o           = (state_q != IDLE) && (state_q != DONE);
    assign done_o           = (state_q == DONE);
    assign err_cnt_o        = err_cnt_q;
    assign first_err_addr_o = first_err_q;

endmodule
`default_nettype wire
